// File: rtl/fp_align_add.sv
// Mantissa-alignment and add stage of the 8-bit floating-point adder.
// Operand value = F * 2^E with E = bits [7:5] and F = bits [4:0].
// The smaller operand's mantissa is shifted right one bit per cycle until
// the exponents match. The mantissas are then added, and the result is
// renormalised once on carry. It saturates to all-ones at the top exponent.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// ALIGN | shifting bMant right, one bit per cycle
// ADD   | single-cycle add / renormalise / saturate
// DONE  | result presented, waiting for out_ready
module fp_align_add #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] aIn,
  input  logic [EXP_W+MAN_W-1:0] bIn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] sum,
  output logic                   overflow
);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  localparam int W = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  state_t            state, state_nxt;
  logic [EXP_W-1:0]  a_exp, cnt;
  logic [MAN_W-1:0]  a_mant, b_mant;
  logic              swap, shift_en;
  logic [EXP_W-1:0]  hi_exp, lo_exp;
  logic [MAN_W-1:0]  hi_mant, lo_mant;
  logic [MAN_W:0]    s6;
  logic [W-1:0]      result;
  logic              result_ovf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign shift_en  = (cnt != '0) && (b_mant != '0);

  // Order fallback: keep the larger exponent in the "a" slot even if upstream misordered.
  always_comb begin
    swap    = aIn[W-1:MAN_W] < bIn[W-1:MAN_W];
    hi_exp  = swap ? bIn[W-1:MAN_W] : aIn[W-1:MAN_W];
    lo_exp  = swap ? aIn[W-1:MAN_W] : bIn[W-1:MAN_W];
    hi_mant = swap ? bIn[MAN_W-1:0] : aIn[MAN_W-1:0];
    lo_mant = swap ? aIn[MAN_W-1:0] : bIn[MAN_W-1:0];
  end

  // Mantissa add with single-step renormalisation and saturation at the top exponent.
  always_comb begin
    s6         = {1'b0, a_mant} + {1'b0, b_mant};
    result     = {a_exp, s6[MAN_W-1:0]};
    result_ovf = 1'b0;
    if (s6[MAN_W]) begin
      if (a_exp != EXP_MAX) begin
        result = {a_exp + 1'b1, s6[MAN_W:1]};
      end else begin
        result     = '1;
        result_ovf = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ALIGN;
      ALIGN:   if (!shift_en) state_nxt = ADD;
      ADD:                    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-cycle alignment shift and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_exp    <= '0;
      a_mant   <= '0;
      b_mant   <= '0;
      cnt      <= '0;
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_exp  <= hi_exp;
          a_mant <= hi_mant;
          b_mant <= lo_mant;
          cnt    <= hi_exp - lo_exp;
        end
        ALIGN: if (shift_en) begin
          b_mant <= b_mant >> 1;
          cnt    <= cnt - 1'b1;
        end
        ADD: begin
          sum      <= result;
          overflow <= result_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Self-checking bench for fp_align_add: directed cases plus random pairs
// against an arithmetic reference model.
module tb_fp_align_add;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] aIn, bIn;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  fp_align_add dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aIn(aIn), .bIn(bIn), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: value arithmetic on whole integers.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] rsum, output logic rovf, output int lat);
    int ea, eb, ma, mb, d, nbits, s, tot;
    ea = a >> 5; ma = a % 32;
    eb = b >> 5; mb = b % 32;
    if (ea < eb) begin
      int t;
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
    end
    d = ea - eb;
    nbits = 0;
    while ((mb >> nbits) != 0) nbits++;
    s = (d < nbits) ? d : nbits;
    lat = s + 2;
    tot = ma + (mb >> d);
    rovf = 1'b0;
    if (tot < 32) rsum = 8'(ea * 32 + tot);
    else if (ea < 7) rsum = 8'((ea + 1) * 32 + tot / 2);
    else begin
      rsum = 8'hFF;
      rovf = 1'b1;
    end
  endtask

  // One full transaction: accept, measure latency, optional backpressure, consume.
  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int hold);
    logic [7:0] esum;
    logic       eovf;
    int         elat, edges;
    model(a, b, esum, eovf, elat);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    aIn = a; bIn = b; in_valid = 1'b1;
    @(posedge clk); #1;
    // Junk held on the input while busy must be ignored.
    aIn = 8'($urandom); bIn = 8'($urandom);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 20) begin
      chk({tag, "_busy_in_ready"}, in_ready, 0);
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, edges, elat);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_ovf"}, overflow, eovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_sum"}, sum, esum);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_consumed_valid"}, out_valid, 0);
    chk({tag, "_consumed_in_ready"}, in_ready, 1);
    chk({tag, "_sum_kept"}, sum, esum);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; aIn = '0; bIn = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn("align_nocarry", 8'b101_10000, 8'b011_10000, 0);
    run_txn("carry_renorm",  8'b010_11000, 8'b010_10000, 0);
    run_txn("saturate",      8'b111_11111, 8'b111_00001, 0);
    run_txn("early_zero",    8'b111_10000, 8'b000_00001, 0);
    run_txn("backpressure",  8'b100_11001, 8'b001_10110, 5);
    run_txn("order_swap",    8'b001_10000, 8'b011_01000, 0);
    run_txn("b_zero",        8'b011_01011, 8'b110_00000, 0);
    run_txn("both_zero",     8'b000_00000, 8'b000_00000, 0);
    run_txn("worst_case",    8'b111_00001, 8'b000_11111, 0);

    // Reset in the middle of alignment discards the operation.
    chk("mid_rst_pre_sum_nonzero", (sum != 0), 1);
    aIn = 8'b111_10000; bIn = 8'b000_11111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_txn("after_rst", 8'b110_10101, 8'b100_11011, 1);

    for (int n = 0; n < 200; n++) begin
      run_txn("rand", 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
